decode_top: RTL and testbench
=============================

DECODE_TOP -- requirements
Module: decode_top

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, datapath width.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports InstrD, PCD, PCPlus4D  input  DATA_WIDTH each  instruction, PC and PC+4 from the fetch pipeline register.
REQ-005 SHALL have ports RegWriteW (input, 1), RdW (input, 5), ResultW (input, DATA_WIDTH)  writeback request.
REQ-006 SHALL have port FlushE  input  1  synchronous bubble insert into the D/E register.
REQ-007 SHALL have ports Rs1D, Rs2D  output  5 each  combinational source indices for the hazard unit.
REQ-008 SHALL have registered outputs RegWriteE(1), ResultSrcE(2), MemWriteE(1), JumpE(1), BranchE(1), ALUControlE(4), ALUSrcAE(1), ALUSrcBE(1), funct3E(3), RD1E, RD2E, ImmExtE, PCE, PCPlus4E (DATA_WIDTH each), RdE, Rs1E, Rs2E (5 each).

Function
REQ-009 SHALL hold a 32 x DATA_WIDTH register file; x0 reads 0 always, and writes to x0 are ignored.
REQ-010 SHALL write ResultW to x[RdW] on a rising clk edge when RegWriteW=1.
REQ-011 SHALL read combinationally, with same-cycle bypass: if RegWriteW=1, RdW!=0 and RdW equals the source index, the read returns ResultW.
REQ-012 SHALL decode the opcode as: R 0110011, I-ALU 0010011, load 0000011, store 0100011, branch 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
REQ-013 SHALL sign-extend immediates: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; J {31,19:12,20,30:21,0}. U is {31:12,12'b0}.
REQ-014 SHALL use ALUControl encoding 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA, 1010 PASS_B.
REQ-015 SHALL drive ALU function as follows:
- R-type: funct3/funct7[5]; SUB only when funct7[5]=1.
- I-ALU: funct3; SRAI when funct7[5]=1 with funct3=101; ADDI never SUB.
- load, store, JALR, AUIPC: ADD.
- branch: SUB.
- LUI: PASS_B.
REQ-016 SHALL encode ResultSrc as 00 ALU, 01 memory, 10 PC+4; load=01, JAL/JALR=10, others 00.
REQ-017 SHALL set RegWrite for R, I-ALU, load, JAL, JALR, LUI and AUIPC.
REQ-018 SHALL set MemWrite for store only, Branch for branch only, and Jump for JAL and JALR.
REQ-019 SHALL set ALUSrcB=1 (immediate) for all non-R, non-branch types, and ALUSrcA=1 (PC) for AUIPC only.
REQ-020 SHALL treat an unrecognised opcode (including 0x00000000) as a bubble: all control bits and ALUControl are 0.
REQ-021 SHALL give the D/E register one-cycle latency: values decoded from the D inputs in cycle n appear on the E outputs after edge n+1.
REQ-022 SHALL make FlushE=1 at an edge load 0 into every E control output and RdE; data fields may load normally.
REQ-023 SHALL give FlushE priority over normal load; a writeback and a flush in the same cycle both take effect.

Reset
REQ-024 SHALL, while rst=1, clear all E outputs and every register-file entry to 0 asynchronously.
REQ-025 SHALL ignore RegWriteW while rst=1, and SHALL resume normal loading at the first rising edge after rst falls.
REQ-026 SHALL, on a reset asserted mid-pipeline, discard the in-flight D/E contents with no partial update.

Verification
REQ-027 Reset, then InstrD=0x00500093 (addi x1,x0,5) -> next edge: RegWriteE=1, ALUSrcBE=1, ALUControlE=0000, ImmExtE=5, RdE=1, RD1E=0.
REQ-028 Write x2=0xDEADBEEF, and in the same cycle decode add x3,x2,x2 (0x002101B3) -> RD1E=RD2E=0xDEADBEEF (bypass).
REQ-029 Attempt to write x0=0x1234 -> a later read of x0 gives 0.
REQ-030 InstrD=0xFE000EE3 (beq x0,x0,-4) -> ImmExtE=0xFFFFFFFC, BranchE=1, ALUControlE=0001, RegWriteE=0.
REQ-031 Decode sw with FlushE=1 -> MemWriteE=0, RegWriteE=0, RdE=0; decode lui x5,0x12345 next -> ImmExtE=0x12345000, ALUControlE=1010.
REQ-032 Assert rst mid-stream while RegWriteE=1 -> all E outputs are 0 immediately, without waiting for clk, and x1 reads 0 afterwards.

Source files
------------

// File: rtl/decode_top.sv
// Decode stage of a five-stage RV32I pipeline: instruction decode, immediate
// generation, register file with writeback bypass, and the D/E pipeline register.
module decode_top #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] InstrD,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  RegWriteW,
  input  logic [4:0]            RdW,
  input  logic [DATA_WIDTH-1:0] ResultW,
  input  logic                  FlushE,
  output logic [4:0]            Rs1D,
  output logic [4:0]            Rs2D,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic [3:0]            ALUControlE,
  output logic                  ALUSrcAE,
  output logic                  ALUSrcBE,
  output logic [2:0]            funct3E,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic [4:0]            RdE,
  output logic [4:0]            Rs1E,
  output logic [4:0]            Rs2E
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_PASS = 4'b1010;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;

  assign instr    = InstrD[31:0];
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];
  assign Rs1D     = instr[19:15];
  assign Rs2D     = instr[24:20];

  // Only R-type may select SUB at funct3=000; ADDI ignores instr[30].
  function automatic logic [3:0] alu_fn(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [3:0] code;
    case (f3)
      3'b000:  code = (is_r && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  code = ALU_SLL;
      3'b010:  code = ALU_SLT;
      3'b011:  code = ALU_SLTU;
      3'b100:  code = ALU_XOR;
      3'b101:  code = alt ? ALU_SRA : ALU_SRL;
      3'b110:  code = ALU_OR;
      default: code = ALU_AND;
    endcase
    return code;
  endfunction

  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  logic                  reg_write_d;
  logic [1:0]            result_src_d;
  logic                  mem_write_d;
  logic                  jump_d;
  logic                  branch_d;
  logic [3:0]            alu_control_d;
  logic                  alu_src_a_d;
  logic                  alu_src_b_d;
  logic [31:0]           imm32_d;
  logic [DATA_WIDTH-1:0] imm_ext_d;

  // Unrecognised opcodes fall through with every control at zero (a bubble).
  always_comb begin
    reg_write_d   = 1'b0;
    result_src_d  = 2'b00;
    mem_write_d   = 1'b0;
    jump_d        = 1'b0;
    branch_d      = 1'b0;
    alu_control_d = ALU_ADD;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 1'b0;
    imm32_d       = 32'd0;
    case (opcode)
      OP_R: begin
        reg_write_d   = 1'b1;
        alu_control_d = alu_fn(funct3, funct7b5, 1'b1);
      end
      OP_I: begin
        reg_write_d   = 1'b1;
        alu_src_b_d   = 1'b1;
        alu_control_d = alu_fn(funct3, funct7b5, 1'b0);
        imm32_d       = imm_i;
      end
      OP_LOAD: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b01;
        alu_src_b_d  = 1'b1;
        imm32_d      = imm_i;
      end
      OP_STORE: begin
        mem_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm32_d     = imm_s;
      end
      OP_BRANCH: begin
        branch_d      = 1'b1;
        alu_control_d = ALU_SUB;
        imm32_d       = imm_b;
      end
      OP_JAL: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
        alu_src_b_d  = 1'b1;
        imm32_d      = imm_j;
      end
      OP_JALR: begin
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        jump_d       = 1'b1;
        alu_src_b_d  = 1'b1;
        imm32_d      = imm_i;
      end
      OP_LUI: begin
        reg_write_d   = 1'b1;
        alu_src_b_d   = 1'b1;
        alu_control_d = ALU_PASS;
        imm32_d       = imm_u;
      end
      OP_AUIPC: begin
        reg_write_d = 1'b1;
        alu_src_a_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm32_d     = imm_u;
      end
      default: ;
    endcase
  end

  assign imm_ext_d = DATA_WIDTH'($signed(imm32_d));

  logic [DATA_WIDTH-1:0] rf_reg [32];
  logic [4:0]            rs_idx [2];
  logic [DATA_WIDTH-1:0] rd_val [2];

  assign rs_idx[0] = instr[19:15];
  assign rs_idx[1] = instr[24:20];

  // Writeback in the same cycle is forwarded so the decoded operand is never stale.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_read
      assign rd_val[gi] = (rs_idx[gi] == 5'd0) ? '0 :
                          (RegWriteW && (RdW == rs_idx[gi])) ? ResultW :
                          rf_reg[rs_idx[gi]];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_reg[i] <= '0;
    end else if (RegWriteW && (RdW != 5'd0)) begin
      rf_reg[RdW] <= ResultW;
    end
  end

  // A flush squashes controls and the destination; operand data still loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteE   <= 1'b0;
      ResultSrcE  <= 2'b00;
      MemWriteE   <= 1'b0;
      JumpE       <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= 4'b0000;
      ALUSrcAE    <= 1'b0;
      ALUSrcBE    <= 1'b0;
      funct3E     <= 3'b000;
      RdE         <= 5'd0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      Rs1E        <= 5'd0;
      Rs2E        <= 5'd0;
    end else begin
      RegWriteE   <= FlushE ? 1'b0    : reg_write_d;
      ResultSrcE  <= FlushE ? 2'b00   : result_src_d;
      MemWriteE   <= FlushE ? 1'b0    : mem_write_d;
      JumpE       <= FlushE ? 1'b0    : jump_d;
      BranchE     <= FlushE ? 1'b0    : branch_d;
      ALUControlE <= FlushE ? 4'b0000 : alu_control_d;
      ALUSrcAE    <= FlushE ? 1'b0    : alu_src_a_d;
      ALUSrcBE    <= FlushE ? 1'b0    : alu_src_b_d;
      funct3E     <= FlushE ? 3'b000  : funct3;
      RdE         <= FlushE ? 5'd0    : instr[11:7];
      RD1E        <= rd_val[0];
      RD2E        <= rd_val[1];
      ImmExtE     <= imm_ext_d;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      Rs1E        <= rs_idx[0];
      Rs2E        <= rs_idx[1];
    end
  end

endmodule

// File: tb/tb_decode_top.sv
// Randomized and directed bench for decode_top, checked against an
// instruction-level reference model with its own register array.
module tb_decode_top;

  logic        clk;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        FlushE;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE, JumpE, BranchE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcAE, ALUSrcBE;
  logic [2:0]  funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  decode_top #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .FlushE(FlushE),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
    .ALUControlE(ALUControlE), .ALUSrcAE(ALUSrcAE), .ALUSrcBE(ALUSrcBE),
    .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int unsigned model_rf [32];

  typedef struct packed {
    logic       rw;
    logic [1:0] rsrc;
    logic       mw;
    logic       jmp;
    logic       br;
    logic       sa;
    logic       sb;
    logic [3:0] alu;
    logic [31:0] imm;
    logic       has_imm;
    logic       is_jal;
  } exp_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // ALU operation named by funct3 in the ISA tables, then mapped to its code.
  function automatic logic [3:0] alu_code(input logic [2:0] f3, input logic alt, input logic is_r);
    logic [3:0] c;
    case (f3)
      3'd0: c = (is_r && alt) ? 4'd1 : 4'd0;
      3'd1: c = 4'd7;
      3'd2: c = 4'd5;
      3'd3: c = 4'd6;
      3'd4: c = 4'd4;
      3'd5: c = alt ? 4'd9 : 4'd8;
      3'd6: c = 4'd3;
      default: c = 4'd2;
    endcase
    return c;
  endfunction

  function automatic exp_t model(input logic [31:0] ins);
    exp_t e;
    int   v_i, v_s, v_b, v_j;
    e = '0;
    v_i = int'(ins) >>> 20;
    v_s = ((int'(ins) >>> 25) * 32) + int'(ins[11:7]);
    v_b = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
    v_j = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
    case (ins[6:0])
      7'h33: begin e.rw = 1; e.alu = alu_code(ins[14:12], ins[30], 1'b1); end
      7'h13: begin e.rw = 1; e.sb = 1; e.alu = alu_code(ins[14:12], ins[30], 1'b0); e.imm = v_i; e.has_imm = 1; end
      7'h03: begin e.rw = 1; e.rsrc = 2'd1; e.sb = 1; e.imm = v_i; e.has_imm = 1; end
      7'h23: begin e.mw = 1; e.sb = 1; e.imm = v_s; e.has_imm = 1; end
      7'h63: begin e.br = 1; e.alu = 4'd1; e.imm = v_b; e.has_imm = 1; end
      7'h6F: begin e.rw = 1; e.rsrc = 2'd2; e.jmp = 1; e.sb = 1; e.imm = v_j; e.has_imm = 1; e.is_jal = 1; end
      7'h67: begin e.rw = 1; e.rsrc = 2'd2; e.jmp = 1; e.sb = 1; e.imm = v_i; e.has_imm = 1; end
      7'h37: begin e.rw = 1; e.sb = 1; e.alu = 4'd10; e.imm = ins & 32'hFFFFF000; e.has_imm = 1; end
      7'h17: begin e.rw = 1; e.sa = 1; e.sb = 1; e.imm = ins & 32'hFFFFF000; e.has_imm = 1; end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx, input logic we,
                                             input logic [4:0] rd, input logic [31:0] res);
    if (idx == 5'd0) return 32'd0;
    if (we && rd == idx) return res;
    return model_rf[idx];
  endfunction

  int step_no = 0;

  // One D-stage cycle: drive at negedge, check E outputs just after the edge.
  task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] rd,
                      input logic [31:0] res, input logic flush);
    exp_t        e;
    logic [31:0] pc, x1, x2;
    logic [7:0]  exp_ctrl;
    @(negedge clk);
    pc = $urandom() & 32'hFFFFFFFC;
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4;
    RegWriteW = we; RdW = rd; ResultW = res; FlushE = flush;
    e  = model(ins);
    x1 = model_read(ins[19:15], we, rd, res);
    x2 = model_read(ins[24:20], we, rd, res);
    exp_ctrl = flush ? 8'd0 : {e.rw, e.rsrc, e.mw, e.jmp, e.br, e.sa, e.sb};
    @(posedge clk);
    #1;
    if (we && rd != 5'd0) model_rf[rd] = res;
    step_no++;
    $display("step %0d instr=%h flush=%b wb=%b x%0d=%h", step_no, ins, flush, we, rd, res);
    chk("ctrl", {24'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUSrcAE, ALUSrcBE},
        {24'd0, exp_ctrl});
    if (!e.is_jal || flush) chk("alu", {28'd0, ALUControlE}, flush ? 32'd0 : {28'd0, e.alu});
    chk("rd", {27'd0, RdE}, flush ? 32'd0 : {27'd0, ins[11:7]});
    chk("rd1", RD1E, x1);
    chk("rd2", RD2E, x2);
    chk("pc", PCE, pc);
    chk("pc4", PCPlus4E, pc + 32'd4);
    chk("rs", {22'd0, Rs1E, Rs2E}, {22'd0, ins[19:15], ins[24:20]});
    if (e.has_imm) chk("imm", ImmExtE, e.imm);
  endtask

  logic [6:0]  ops [10];
  logic [31:0] r;
  int          k;

  initial begin
    ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03; ops[3] = 7'h23; ops[4] = 7'h63;
    ops[5] = 7'h6F; ops[6] = 7'h67; ops[7] = 7'h37; ops[8] = 7'h17; ops[9] = 7'h7F;
    for (int i = 0; i < 32; i++) model_rf[i] = 0;
    rst = 1'b1; InstrD = 32'h00500093; PCD = 32'h100; PCPlus4D = 32'h104;
    RegWriteW = 1'b0; RdW = 5'd0; ResultW = 32'd0; FlushE = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctrl", {20'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcAE, ALUSrcBE},
        32'd0);
    chk("reset_data", RD1E | RD2E | ImmExtE | PCE | PCPlus4E, 32'd0);
    chk("reset_idx", {14'd0, RdE, Rs1E, Rs2E, funct3E}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // addi x1,x0,5
    step(32'h00500093, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("addi_rw", {31'd0, RegWriteE}, 32'd1);
    chk("addi_imm", ImmExtE, 32'd5);
    chk("addi_rd1", RD1E, 32'd0);
    // add x3,x2,x2 while writing x2
    step(32'h002101B3, 1'b1, 5'd2, 32'hDEADBEEF, 1'b0);
    chk("bypass_rd1", RD1E, 32'hDEADBEEF);
    chk("bypass_rd2", RD2E, 32'hDEADBEEF);
    // write x0, then read x0 through add x4,x0,x0
    step(32'h00000013, 1'b1, 5'd0, 32'h00001234, 1'b0);
    step(32'h00000233, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("x0_zero", RD1E, 32'd0);
    // beq x0,x0,-4
    step(32'hFE000EE3, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("beq_imm", ImmExtE, 32'hFFFFFFFC);
    chk("beq_alu", {28'd0, ALUControlE}, 32'd1);
    // flushed sw, then lui x5,0x12345 alongside a writeback
    step(32'h00112023, 1'b1, 5'd7, 32'h0BADF00D, 1'b1);
    chk("flush_mw", {31'd0, MemWriteE}, 32'd0);
    step(32'h123452B7, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("lui_imm", ImmExtE, 32'h12345000);
    chk("lui_alu", {28'd0, ALUControlE}, 32'd10);
    // all-zero instruction is a bubble
    step(32'h00000000, 1'b0, 5'd0, 32'd0, 1'b0);

    for (k = 0; k < 300; k++) begin
      r = $urandom();
      step({r[31:7], ops[$urandom_range(0, 9)]}, 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom(), ($urandom_range(0, 7) == 0));
    end

    // Load x1, decode an instruction that writes, then reset between edges.
    step(32'h00000013, 1'b1, 5'd1, 32'h55AA55AA, 1'b0);
    step(32'h00108093, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("pre_rst_rw", {31'd0, RegWriteE}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_ctrl", {20'd0, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcAE, ALUSrcBE},
        32'd0);
    chk("async_data", RD1E | RD2E | ImmExtE | PCE | PCPlus4E, 32'd0);
    chk("async_idx", {14'd0, RdE, Rs1E, Rs2E, funct3E}, 32'd0);
    RegWriteW = 1'b1; RdW = 5'd1; ResultW = 32'h77777777;
    @(posedge clk);
    @(negedge clk);
    RegWriteW = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 0;
    step(32'h001082B3, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("x1_after_rst", RD1E, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
